// File: rtl/or1200_checker_ctrl_if.sv
// Bundles the privilege-checker health inputs and the response outputs of
// or1200_checker_ctrl so they can be passed as one port.
interface or1200_checker_ctrl_if;
  logic       sr_ok;
  logic       pipeline_ok;
  logic       mmus_ok;
  logic [2:0] secure_supv;
  logic       sr_sm;
  logic       strike_clr;
  logic       alarm;
  logic       freeze_req;
  logic       flush_req;
  logic       locked;
  logic [1:0] strikes;
  logic [3:0] fault_cause;

  modport master (
    output sr_ok, pipeline_ok, mmus_ok, secure_supv, sr_sm, strike_clr,
    input  alarm, freeze_req, flush_req, locked, strikes, fault_cause
  );

  modport slave (
    input  sr_ok, pipeline_ok, mmus_ok, secure_supv, sr_sm, strike_clr,
    output alarm, freeze_req, flush_req, locked, strikes, fault_cause
  );
endinterface

// File: rtl/or1200_checker_ctrl.sv
// Response sequencer for the OR1200 privilege checker: confirms persistent
// violations, drives a timed freeze/flush, counts strikes and locks the core.
module or1200_checker_ctrl #(
  parameter int unsigned CONFIRM_CYCLES = 2,
  parameter int unsigned RECOVER_CYCLES = 4,
  parameter int unsigned MASK_CYCLES    = 3,
  parameter int unsigned STRIKE_MAX     = 3
) (
  input logic                 clk,
  input logic                 rst,
  or1200_checker_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_INIT,
    S_MONITOR,
    S_SUSPECT,
    S_FLUSH,
    S_LOCKED
  } state_t;

  localparam logic [3:0] MASK_LAST    = 4'(MASK_CYCLES - 1);
  localparam logic [3:0] CONFIRM_LAST = 4'(CONFIRM_CYCLES - 1);
  localparam logic [3:0] RECOVER_LAST = 4'(RECOVER_CYCLES - 1);
  localparam logic [1:0] STRIKE_LIM   = 2'(STRIKE_MAX);
  localparam bit         CONFIRM_NOW  = (CONFIRM_CYCLES == 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] strikes_q, strikes_d;
  logic [3:0] cause_q, cause_d;
  logic       alarm_q, alarm_d;
  logic       freeze_q, freeze_d;
  logic       flush_q, flush_d;
  logic       locked_q, locked_d;

  logic [3:0] f;
  logic       fault;
  logic       confirm;

  always_comb begin
    f     = {((~^bus.secure_supv) != bus.sr_sm), ~bus.mmus_ok,
             ~bus.pipeline_ok, ~bus.sr_ok};
    fault = |f;

    state_d   = state_q;
    cnt_d     = cnt_q;
    strikes_d = strikes_q;
    cause_d   = cause_q;
    confirm   = 1'b0;

    if (state_q != S_LOCKED && bus.strike_clr) begin
      strikes_d = '0;
      cause_d   = '0;
    end

    case (state_q)
      S_INIT: begin
        if (cnt_q == MASK_LAST) begin
          state_d = S_MONITOR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_MONITOR: begin
        if (fault) begin
          if (CONFIRM_NOW) begin
            confirm = 1'b1;
          end else begin
            state_d = S_SUSPECT;
            cnt_d   = 4'd1;
          end
        end
      end
      S_SUSPECT: begin
        if (!fault) begin
          state_d = S_MONITOR;
          cnt_d   = '0;
        end else if (cnt_q == CONFIRM_LAST) begin
          confirm = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_FLUSH: begin
        if (cnt_q == RECOVER_LAST) begin
          state_d = (strikes_q == STRIKE_LIM) ? S_LOCKED : S_INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_LOCKED: begin
        state_d = S_LOCKED;
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase

    // A confirming edge overrides any same-edge strike_clr: the new strike survives.
    if (confirm) begin
      state_d = S_FLUSH;
      cnt_d   = '0;
      if (bus.strike_clr) begin
        strikes_d = 2'd1;
        cause_d   = f;
      end else begin
        strikes_d = (strikes_q == 2'd3) ? 2'd3 : strikes_q + 2'd1;
        cause_d   = cause_q | f;
      end
    end

    // Outputs are decoded from the next state so the registered copies track state_q.
    flush_d  = (state_d == S_FLUSH);
    locked_d = (state_d == S_LOCKED);
    freeze_d = flush_d | locked_d;
    alarm_d  = flush_d | locked_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      strikes_q <= '0;
      cause_q   <= '0;
      alarm_q   <= 1'b0;
      freeze_q  <= 1'b0;
      flush_q   <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      strikes_q <= strikes_d;
      cause_q   <= cause_d;
      alarm_q   <= alarm_d;
      freeze_q  <= freeze_d;
      flush_q   <= flush_d;
      locked_q  <= locked_d;
    end
  end

  assign bus.alarm       = alarm_q;
  assign bus.freeze_req  = freeze_q;
  assign bus.flush_req   = flush_q;
  assign bus.locked      = locked_q;
  assign bus.strikes     = strikes_q;
  assign bus.fault_cause = cause_q;

endmodule

// File: tb/tb_or1200_checker_ctrl.sv
// Self-checking bench for or1200_checker_ctrl: directed vector table, corner
// sequences and randomized stimulus against a counter-based reference model.
module tb_or1200_checker_ctrl;

  localparam int unsigned CONF = 2;
  localparam int unsigned REC  = 4;
  localparam int unsigned MASK = 3;
  localparam int unsigned SMAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  or1200_checker_ctrl_if bus();

  or1200_checker_ctrl #(
    .CONFIRM_CYCLES(CONF),
    .RECOVER_CYCLES(REC),
    .MASK_CYCLES(MASK),
    .STRIKE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remaining mask/recover cycles and length of the current fault run.
  int         m_mask, m_run, m_rec, m_strikes;
  bit         m_locked;
  logic [3:0] m_cause;

  typedef struct {
    logic       sr, pp, mm;
    logic [2:0] sv;
    logic       sm, clr;
    logic [9:0] exp;   // {alarm, freeze, flush, locked, strikes[1:0], cause[3:0]}
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mkv(logic sr, logic pp, logic mm, logic [2:0] sv,
                               logic sm, logic clr, logic [9:0] e);
    vec_t v;
    v.sr = sr; v.pp = pp; v.mm = mm; v.sv = sv; v.sm = sm; v.clr = clr; v.exp = e;
    return v;
  endfunction

  function automatic logic [3:0] fvec(logic sr, logic pp, logic mm,
                                      logic [2:0] sv, logic sm);
    logic supv;
    supv = ($countones(sv) % 2 == 0);
    return {supv != sm, !mm, !pp, !sr};
  endfunction

  function automatic logic [9:0] outs();
    return {bus.alarm, bus.freeze_req, bus.flush_req, bus.locked,
            bus.strikes, bus.fault_cause};
  endfunction

  function automatic logic [9:0] mexp();
    logic fl;
    fl = (m_rec > 0);
    return {fl | m_locked, fl | m_locked, fl, m_locked, 2'(m_strikes), m_cause};
  endfunction

  task automatic model_reset();
    m_mask = MASK; m_run = 0; m_rec = 0; m_strikes = 0; m_locked = 0; m_cause = '0;
  endtask

  task automatic model_edge(input logic [3:0] f, input logic clr);
    if (m_locked) return;
    if (m_rec > 0) begin
      m_rec--;
      if (m_rec == 0) begin
        if (m_strikes == SMAX) m_locked = 1;
        else m_mask = MASK;
      end
      if (clr) begin m_strikes = 0; m_cause = '0; end
    end else if (m_mask > 0) begin
      m_mask--;
      if (clr) begin m_strikes = 0; m_cause = '0; end
    end else begin
      if (f != 0) m_run++;
      else m_run = 0;
      if (m_run == CONF) begin
        m_run = 0;
        if (clr) begin m_strikes = 0; m_cause = '0; end
        if (m_strikes < 3) m_strikes++;
        m_cause = m_cause | f;
        m_rec = REC;
      end else if (clr) begin
        m_strikes = 0; m_cause = '0;
      end
    end
  endtask

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b (alarm,freeze,flush,locked,strikes,cause) t=%0t",
               name, got, exp, $time);
    end
  endtask

  task automatic step(input logic sr, input logic pp, input logic mm,
                      input logic [2:0] sv, input logic sm, input logic clr);
    bus.sr_ok = sr; bus.pipeline_ok = pp; bus.mmus_ok = mm;
    bus.secure_supv = sv; bus.sr_sm = sm; bus.strike_clr = clr;
    @(posedge clk);
    model_edge(fvec(sr, pp, mm, sv, sm), clr);
    #1 check("model", outs(), mexp());
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 1, 3'b000, 1, 0);
  endtask

  task automatic supv_burst();
    step(1, 1, 1, 3'b001, 1, 0);
    step(1, 1, 1, 3'b001, 1, 0);
    idle(8);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sr_ok = 1; bus.pipeline_ok = 1; bus.mmus_ok = 1;
    bus.secure_supv = 3'b000; bus.sr_sm = 1; bus.strike_clr = 0;
    @(negedge clk);
    #1 check("reset_state", outs(), 10'b0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    // Rows follow reset release: 3 masked edges, then MONITOR.
    tbl[0]  = mkv(1, 1, 1, 3'b000, 1, 0, 10'b0000_00_0000);
    tbl[1]  = mkv(1, 1, 1, 3'b000, 1, 0, 10'b0000_00_0000);
    tbl[2]  = mkv(1, 1, 1, 3'b000, 1, 0, 10'b0000_00_0000);
    tbl[3]  = mkv(1, 1, 1, 3'b000, 1, 0, 10'b0000_00_0000);
    tbl[4]  = mkv(1, 1, 0, 3'b000, 1, 0, 10'b0000_00_0000);
    tbl[5]  = mkv(1, 1, 0, 3'b000, 1, 0, 10'b1110_01_0100);
    tbl[6]  = mkv(1, 1, 1, 3'b000, 1, 0, 10'b1110_01_0100);
    tbl[7]  = mkv(1, 1, 1, 3'b000, 1, 0, 10'b1110_01_0100);
    tbl[8]  = mkv(1, 1, 1, 3'b000, 1, 0, 10'b1110_01_0100);
    tbl[9]  = mkv(1, 1, 1, 3'b000, 1, 0, 10'b0000_01_0100);
    tbl[10] = mkv(1, 1, 0, 3'b000, 1, 0, 10'b0000_01_0100);
    tbl[11] = mkv(1, 1, 0, 3'b000, 1, 0, 10'b0000_01_0100);
    tbl[12] = mkv(1, 1, 0, 3'b000, 1, 0, 10'b0000_01_0100);
    tbl[13] = mkv(0, 1, 1, 3'b000, 1, 0, 10'b0000_01_0100);
    tbl[14] = mkv(1, 1, 1, 3'b000, 1, 0, 10'b0000_01_0100);
    tbl[15] = mkv(1, 1, 1, 3'b000, 1, 0, 10'b0000_01_0100);
    tbl[16] = mkv(1, 1, 1, 3'b000, 1, 1, 10'b0000_00_0000);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].sr, tbl[i].pp, tbl[i].mm, tbl[i].sv, tbl[i].sm, tbl[i].clr);
      check($sformatf("table[%0d]", i), outs(), tbl[i].exp);
    end
    idle(50);
    check("quiet_50", outs(), 10'b0);

    // Three confirmed supervisor mismatches end in permanent lock.
    do_reset();
    idle(5);
    supv_burst();
    supv_burst();
    supv_burst();
    check("locked_state", outs(), 10'b1101_11_1000);
    step(0, 0, 0, 3'b001, 1, 1);
    check("lock_ignores_clr", outs(), 10'b1101_11_1000);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst_lock", outs(), 10'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    model_reset();

    // strike_clr on the confirming edge with two strikes already recorded.
    idle(5);
    supv_burst();
    supv_burst();
    check("two_strikes", outs(), 10'b0000_10_1000);
    step(1, 0, 1, 3'b000, 1, 0);
    step(1, 0, 1, 3'b000, 1, 1);
    check("clr_on_confirm", outs(), 10'b1110_01_0010);
    idle(8);
    step(1, 1, 1, 3'b000, 1, 1);
    check("clr_in_monitor", outs(), 10'b0);

    // Reset during the second FLUSH cycle.
    do_reset();
    idle(5);
    step(1, 1, 0, 3'b000, 1, 0);
    step(1, 1, 0, 3'b000, 1, 0);
    @(posedge clk);
    #1 check("flush_2nd_cycle", outs(), 10'b1110_01_0100);
    #1 rst = 1'b1;
    #1 check("async_rst_flush", outs(), 10'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    model_reset();
    step(0, 0, 0, 3'b000, 1, 0);
    step(0, 0, 0, 3'b000, 1, 0);
    step(0, 0, 0, 3'b000, 1, 0);
    check("restart_masked", outs(), 10'b0);
    step(1, 1, 1, 3'b000, 0, 0);
    step(1, 1, 1, 3'b000, 0, 0);
    check("restart_strike1", outs(), 10'b1110_01_1000);

    // Randomized stimulus against the model, reset between rounds.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < 400; i++) begin
        logic [2:0] sv;
        logic       even;
        sv   = 3'($urandom_range(7));
        even = ($countones(sv) % 2 == 0);
        step($urandom_range(7) != 0, $urandom_range(7) != 0, $urandom_range(7) != 0,
             sv, ($urandom_range(9) != 0) ? even : !even, $urandom_range(40) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/or1200_checker_ctrl.md
# or1200_checker_ctrl

Response sequencer for the OR1200 CPU-level privilege checker. It samples the checker's health outputs (`sr_ok`, `pipeline_ok`, `mmus_ok`, `secure_supv`) every cycle and cross-checks the decoded supervisor bit against the CPU's `SR[SM]`. A violation must persist before it is confirmed. Once confirmed, the block drives a timed freeze/flush of the pipeline, counts strikes, and locks the core after too many confirmed violations.

## Interface
- `CONFIRM_CYCLES`, 2, consecutive faulty samples needed to confirm a violation (1..15).
- `RECOVER_CYCLES`, 4, cycles `flush_req`/`freeze_req` are held per confirmed violation (1..15).
- `MASK_CYCLES`, 3, cycles checker inputs are ignored after reset and after each recovery (1..15).
- `STRIKE_MAX`, 3, confirmed violations that cause permanent lock (1..3).

- `clk`  in  1  core clock; the single clock for the block.
- `rst`  in  1  asynchronous, active-high reset.
- `sr_ok`  in  1  checker: SR writes consistent.
- `pipeline_ok`  in  1  checker: pipeline/flush consistent.
- `mmus_ok`  in  1  checker: MMU enables consistent.
- `secure_supv`  in  3  checker parity-encoded supervisor bit. Even parity = supervisor.
- `sr_sm`  in  1  CPU `SR[SM]`.
- `strike_clr`  in  1  debug-unit pulse: clear strikes and cause.
- `alarm`  out  1  violation being handled or core locked.
- `freeze_req`  out  1  request CPU freeze.
- `flush_req`  out  1  request pipeline flush.
- `locked`  out  1  permanent lock, released only by `rst`.
- `strikes`  out  2  confirmed-violation count.
- `fault_cause`  out  4  sticky `{supv, mmu, pipe, sr}` causes of confirmed violations.

## Operation
- Fault vector, combinational: `f = {(~^secure_supv) != sr_sm, ~mmus_ok, ~pipeline_ok, ~sr_ok}`, and `fault = |f`.
- State machine has five states: `INIT`, `MONITOR`, `SUSPECT`, `FLUSH`, `LOCKED`. It uses a 4-bit counter `cnt`.
- `INIT`: all fault inputs are ignored. `cnt` counts up from 0. When `cnt == MASK_CYCLES-1`, go to `MONITOR` with `cnt` = 0.
- `MONITOR`:
  - If `fault` and `CONFIRM_CYCLES == 1`, go to `FLUSH`.
  - If `fault` and `CONFIRM_CYCLES > 1`, go to `SUSPECT` with `cnt` = 1.
  - Otherwise stay.
- `SUSPECT`:
  - If `!fault`, return to `MONITOR` with `cnt` = 0. A single clean sample cancels the suspicion.
  - If `fault` and `cnt == CONFIRM_CYCLES-1`, go to `FLUSH`.
  - Otherwise increment `cnt`.
- Entry to `FLUSH` (the confirming edge):
  - `strikes` increments, saturating at 3.
  - `fault_cause` is OR-ed with the `f` sampled on that edge.
  - `cnt` is set to 0.
- `FLUSH`:
  - `cnt` counts up. When `cnt == RECOVER_CYCLES-1`:
    - if `strikes == STRIKE_MAX`, go to `LOCKED`;
    - else go to `INIT`, which re-masks inputs while the flush settles.
  - Faults are ignored in this state.
- `LOCKED`: absorbing state. Faults and `strike_clr` are ignored; only `rst` exits.
- `strike_clr`:
  - In any state except `LOCKED`, it clears `strikes` and `fault_cause` on the next edge.
  - If it coincides with a `FLUSH` entry, the increment wins: `strikes` = 1 and `fault_cause` = `f`.

## Timing
- All outputs are registered, Moore-decoded from state, with no combinational input-to-output path.
- `flush_req` = `freeze_req` = `alarm` = 1 in `FLUSH`.
- `freeze_req` = `alarm` = `locked` = 1 in `LOCKED`. `flush_req` = 0 in `LOCKED`.
- All outputs are 0 elsewhere.
- Reset values: state = `INIT`, `cnt` = 0. `alarm`, `freeze_req`, `flush_req`, `locked`, `strikes` and `fault_cause` are all 0.
- Reset takes effect asynchronously from any state, including mid-`FLUSH`; outputs drop immediately.
- Detection latency: suppose `fault` is sampled high on edges k through k+CONFIRM_CYCLES-1, counted from the first `MONITOR` edge. Then `flush_req` rises immediately after edge k+CONFIRM_CYCLES-1 and stays high for exactly `RECOVER_CYCLES` cycles.
- First `MONITOR` sample after reset deassertion is the edge following `MASK_CYCLES` edges spent in `INIT`.
- `LOCKED` is entered on the edge that ends the final `FLUSH`. `flush_req` falls and `locked` rises on that same edge.

## Test plan
- Reset, all inputs ok with `secure_supv` = 3'b000 and `sr_sm` = 1 → outputs stay 0; state reaches `MONITOR` after 3 edges; no alarm for 50 cycles.
- Single-cycle `sr_ok` = 0 glitch in `MONITOR` → `SUSPECT`, then back to `MONITOR`; `alarm` never rises; `strikes` = 0.
- `mmus_ok` = 0 for 2 cycles → `flush_req` high for exactly 4 cycles starting the cycle after the 2nd sample; `strikes` = 1; `fault_cause` = 4'b0100; then 3 masked cycles, then `MONITOR`.
- `secure_supv` = 3'b001 with `sr_sm` = 1, three separated 2-cycle bursts → third flush ends in `LOCKED`: `locked` = `freeze_req` = 1, `flush_req` = 0, `fault_cause` = 4'b1000. Assert `strike_clr` → no change. Assert `rst` → all outputs 0.
- `strike_clr` on the confirming edge with `strikes` = 2 → `strikes` = 1 and `fault_cause` = sampled `f`. `strike_clr` alone in `MONITOR` → both cleared.
- `rst` asserted in the 2nd `FLUSH` cycle → `flush_req`/`alarm` drop asynchronously; after release the block restarts in `INIT` with `strikes` = 0.
